// File: rtl/program_sequencer.sv
// Program sequencer: generates the instruction address stream.
// The PC steps by 2. Branches, jumps and interrupts redirect it.
// A return stack holds call and interrupt return addresses.
// HALT freezes the PC until an enabled interrupt arrives.
module program_sequencer #(
  parameter int              PC_W        = 16,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] INT_VECTOR  = 'h0010
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clk_en,
  input  logic            branch_taken,
  input  logic [5:0]      branch_immediate,
  input  logic            jump_taken,
  input  logic            jump_link,
  input  logic [11:0]     jump_immediate,
  input  logic            return_cmd,
  input  logic            int_trigger,
  input  logic            int_enable_cmd,
  input  logic            int_disable_cmd,
  input  logic            halt_cmd,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            int_enabled,
  output logic [4:0]      stack_count,
  output logic            stack_overflow,
  output logic            stack_underflow
);

  localparam int IDX_W = (STACK_DEPTH <= 2) ? 1 : $clog2(STACK_DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [PC_W-1:0] ret;
    logic            irq_tag;
  } stk_ent_t;

  state_t          state;
  stk_ent_t        stk [STACK_DEPTH];

  logic [PC_W-1:0] pc_inc, br_tgt, jmp_tgt;
  logic            take_irq, full, empty, push_req, push_wr;
  logic [IDX_W-1:0] wr_idx, top_idx;
  stk_ent_t        top;

  // Next-PC candidates, stack pointers and the push decision.
  // Immediates are word offsets, so they are shifted left by one before the add.
  always_comb begin
    pc_inc   = pc + PC_W'(2);
    br_tgt   = pc_inc + {{(PC_W-7){branch_immediate[5]}}, branch_immediate, 1'b0};
    jmp_tgt  = pc_inc + {{(PC_W-13){jump_immediate[11]}}, jump_immediate, 1'b0};
    take_irq = int_trigger & int_enabled;
    full     = (stack_count == 5'(STACK_DEPTH));
    empty    = (stack_count == 5'd0);
    wr_idx   = IDX_W'(stack_count);
    top_idx  = IDX_W'(stack_count - 5'd1);
    top      = stk[top_idx];
    // A linked jump pushes only when it is the winning RUN event.
    push_req = clk_en & (take_irq |
               ((state == RUN) & ~halt_cmd & ~return_cmd & jump_taken & jump_link));
    push_wr  = push_req & ~full;
  end

  // Stack storage. Entries are not reset; stack_count alone marks them valid.
  always_ff @(posedge clk) begin
    if (push_wr) stk[wr_idx] <= '{ret: pc_inc, irq_tag: take_irq};
  end

  // Main sequencer FSM. Interrupt outranks everything, in both RUN and HALT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= RUN;
      pc              <= '0;
      halted          <= 1'b0;
      int_enabled     <= 1'b0;
      stack_count     <= 5'd0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else if (clk_en) begin
      if (take_irq) begin
        state       <= RUN;
        halted      <= 1'b0;
        pc          <= INT_VECTOR;
        int_enabled <= 1'b0;
        if (full) stack_overflow <= 1'b1;
        else      stack_count    <= stack_count + 5'd1;
      end else if (state == RUN) begin
        // Enable commands ride along with any non-interrupt event; disable wins.
        if (int_disable_cmd)     int_enabled <= 1'b0;
        else if (int_enable_cmd) int_enabled <= 1'b1;
        if (halt_cmd) begin
          state  <= HALT;
          halted <= 1'b1;
        end else if (return_cmd) begin
          if (empty) begin
            pc              <= pc_inc;
            stack_underflow <= 1'b1;
          end else begin
            pc          <= top.ret;
            stack_count <= stack_count - 5'd1;
            if (top.irq_tag) int_enabled <= 1'b1;
          end
        end else if (jump_taken) begin
          pc <= jmp_tgt;
          if (jump_link) begin
            if (full) stack_overflow <= 1'b1;
            else      stack_count    <= stack_count + 5'd1;
          end
        end else if (branch_taken) begin
          pc <= br_tgt;
        end else begin
          pc <= pc_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: one table of per-cycle vectors
// walks the sequencer through sequencing, branches, calls, stack limits,
// interrupts and HALT. A hand-written tail covers asynchronous reset.
module tb_program_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        branch_taken;
  logic [5:0]  branch_immediate;
  logic        jump_taken;
  logic        jump_link;
  logic [11:0] jump_immediate;
  logic        return_cmd;
  logic        int_trigger;
  logic        int_enable_cmd;
  logic        int_disable_cmd;
  logic        halt_cmd;
  logic [15:0] pc;
  logic        halted;
  logic        int_enabled;
  logic [4:0]  stack_count;
  logic        stack_overflow;
  logic        stack_underflow;

  int total = 0;
  int bad   = 0;

  program_sequencer dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .branch_taken(branch_taken), .branch_immediate(branch_immediate),
    .jump_taken(jump_taken), .jump_link(jump_link), .jump_immediate(jump_immediate),
    .return_cmd(return_cmd), .int_trigger(int_trigger),
    .int_enable_cmd(int_enable_cmd), .int_disable_cmd(int_disable_cmd),
    .halt_cmd(halt_cmd), .pc(pc), .halted(halted), .int_enabled(int_enabled),
    .stack_count(stack_count), .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  // Command bitmask used by the table.
  localparam logic [7:0] BR = 8'h80, JT = 8'h40, JL = 8'h20, RT = 8'h10,
                         IRQ = 8'h08, IEN = 8'h04, IDIS = 8'h02, HLT = 8'h01;

  typedef struct {
    logic        en;
    logic [7:0]  cmd;
    logic [5:0]  bimm;
    logic [11:0] jimm;
    logic [24:0] exp;   // {pc, halted, int_enabled, stack_count, ovf, unf}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic en, input logic [7:0] cmd,
                              input logic [5:0] bimm, input logic [11:0] jimm,
                              input logic [15:0] epc, input logic eh, input logic eie,
                              input logic [4:0] ecnt, input logic eovf, input logic eunf);
    vec_t v;
    v.en = en; v.cmd = cmd; v.bimm = bimm; v.jimm = jimm;
    v.exp = {epc, eh, eie, ecnt, eovf, eunf};
    return v;
  endfunction

  function automatic logic [24:0] obs();
    return {pc, halted, int_enabled, stack_count, stack_overflow, stack_underflow};
  endfunction

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got pc=%h h=%b ie=%b cnt=%0d ovf=%b unf=%b, want pc=%h h=%b ie=%b cnt=%0d ovf=%b unf=%b",
               name, act[24:9], act[8], act[7], act[6:2], act[1], act[0],
               exp[24:9], exp[8], exp[7], exp[6:2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input vec_t v);
    clk_en           = v.en;
    branch_taken     = v.cmd[7];
    jump_taken       = v.cmd[6];
    jump_link        = v.cmd[5];
    return_cmd       = v.cmd[4];
    int_trigger      = v.cmd[3];
    int_enable_cmd   = v.cmd[2];
    int_disable_cmd  = v.cmd[1];
    halt_cmd         = v.cmd[0];
    branch_immediate = v.bimm;
    jump_immediate   = v.jimm;
  endtask

  initial begin
    //           en cmd      bimm   jimm     pc       h  ie cnt  ovf unf
    // sequential stepping, then clk_en low holds everything
    vecs.push_back(mk(1, 8'h00,   6'h00, 12'h000, 16'h0002, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00,   6'h00, 12'h000, 16'h0004, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00,   6'h00, 12'h000, 16'h0006, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00,   6'h00, 12'h000, 16'h0008, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, JT,      6'h00, 12'h005, 16'h0008, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, RT|HLT,  6'h00, 12'h000, 16'h0008, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00,   6'h00, 12'h000, 16'h0008, 0, 0, 0, 0, 0));
    // negative branch, then wrap past 0xFFFE
    vecs.push_back(mk(1, JT,      6'h00, 12'h00B, 16'h0020, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, BR,      6'h3E, 12'h000, 16'h001E, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, JT,      6'h00, 12'hFEF, 16'hFFFE, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8'h00,   6'h00, 12'h000, 16'h0000, 0, 0, 0, 0, 0));
    // call and return
    vecs.push_back(mk(1, JT,      6'h00, 12'h07F, 16'h0100, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, JT|JL,   6'h00, 12'h010, 16'h0122, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, RT,      6'h00, 12'h000, 16'h0102, 0, 0, 0, 0, 0));
    // fill the stack, overflow, drain, underflow
    vecs.push_back(mk(1, JT|JL,   6'h00, 12'h000, 16'h0104, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, JT|JL,   6'h00, 12'h000, 16'h0106, 0, 0, 2, 0, 0));
    vecs.push_back(mk(1, JT|JL,   6'h00, 12'h000, 16'h0108, 0, 0, 3, 0, 0));
    vecs.push_back(mk(1, JT|JL,   6'h00, 12'h000, 16'h010A, 0, 0, 4, 0, 0));
    vecs.push_back(mk(1, JT|JL,   6'h00, 12'h000, 16'h010C, 0, 0, 4, 1, 0));
    vecs.push_back(mk(1, RT,      6'h00, 12'h000, 16'h010A, 0, 0, 3, 1, 0));
    vecs.push_back(mk(1, RT,      6'h00, 12'h000, 16'h0108, 0, 0, 2, 1, 0));
    vecs.push_back(mk(1, RT,      6'h00, 12'h000, 16'h0106, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, RT,      6'h00, 12'h000, 16'h0104, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, RT,      6'h00, 12'h000, 16'h0106, 0, 0, 0, 1, 1));
    // interrupt beats a jump, return restores the enable
    vecs.push_back(mk(1, IEN,     6'h00, 12'h000, 16'h0108, 0, 1, 0, 1, 1));
    vecs.push_back(mk(1, JT,      6'h00, 12'hF9B, 16'h0040, 0, 1, 0, 1, 1));
    vecs.push_back(mk(1, IRQ|JT,  6'h00, 12'h123, 16'h0010, 0, 0, 1, 1, 1));
    vecs.push_back(mk(1, RT,      6'h00, 12'h000, 16'h0042, 0, 1, 0, 1, 1));
    // disable wins over enable; a disabled request is dropped
    vecs.push_back(mk(1, IEN|IDIS,6'h00, 12'h000, 16'h0044, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, IRQ,     6'h00, 12'h000, 16'h0046, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, IEN,     6'h00, 12'h000, 16'h0048, 0, 1, 0, 1, 1));
    // HALT freezes, ignores non-interrupt inputs, wakes on interrupt
    vecs.push_back(mk(1, JT,      6'h00, 12'h003, 16'h0050, 0, 1, 0, 1, 1));
    vecs.push_back(mk(1, HLT,     6'h00, 12'h000, 16'h0050, 1, 1, 0, 1, 1));
    vecs.push_back(mk(1, JT|JL,   6'h00, 12'h007, 16'h0050, 1, 1, 0, 1, 1));
    vecs.push_back(mk(1, RT,      6'h00, 12'h000, 16'h0050, 1, 1, 0, 1, 1));
    vecs.push_back(mk(1, BR,      6'h05, 12'h000, 16'h0050, 1, 1, 0, 1, 1));
    vecs.push_back(mk(1, IDIS,    6'h00, 12'h000, 16'h0050, 1, 1, 0, 1, 1));
    vecs.push_back(mk(1, HLT|IEN, 6'h00, 12'h000, 16'h0050, 1, 1, 0, 1, 1));
    vecs.push_back(mk(1, IRQ,     6'h00, 12'h000, 16'h0010, 0, 0, 1, 1, 1));
    vecs.push_back(mk(1, RT,      6'h00, 12'h000, 16'h0052, 0, 1, 0, 1, 1));

    // reset state
    reset = 1'b1;
    drive(mk(0, 8'h00, 6'h00, 12'h000, 16'h0000, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", obs(), 25'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end

    // asynchronous reset between edges clears state at once
    drive(mk(1, JT|JL, 6'h00, 12'h040, 16'h0000, 0, 0, 0, 0, 0));
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", obs(), 25'd0);
    @(posedge clk);
    #1;
    check("reset_held", obs(), 25'd0);
    drive(mk(1, 8'h00, 6'h00, 12'h000, 16'h0000, 0, 0, 0, 0, 0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_step", obs(), {16'h0002, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
